// File: rtl/csb_apb_pkg.sv
// ---------------------------------------------------------------------------
// csb_apb_pkg : shared types and helpers for the CSB-to-APB bridge. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package csb_apb_pkg;

  localparam int CSB_AW = 16;
  localparam int DW     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // CSB carries word addresses; APB wants a byte address under the base window.
  function automatic logic [DW-1:0] make_paddr(input logic [13:0] base_hi,
                                               input logic [CSB_AW-1:0] addr);
    return {base_hi, addr, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/csb2apb_bridge_if.sv
// ---------------------------------------------------------------------------
// csb2apb_bridge_if : CSB request/response and APB3 signals of the bridge. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface csb2apb_bridge_if;
  import csb_apb_pkg::*;

  logic              csb2nvdla_valid;
  logic              csb2nvdla_ready;
  logic [CSB_AW-1:0] csb2nvdla_addr;
  logic [DW-1:0]     csb2nvdla_wdat;
  logic              csb2nvdla_write;
  logic              csb2nvdla_nposted;
  logic              nvdla2csb_valid;
  logic [DW-1:0]     nvdla2csb_data;
  logic              nvdla2csb_wr_complete;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;
  logic              bridge_err;

  // Bridge side: CSB responder, APB requester.
  modport slave (
    input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write,
           csb2nvdla_nposted, prdata, pready, pslverr,
    output csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
           psel, penable, pwrite, paddr, pwdata, bridge_err
  );

  // Environment side: CSB requester and APB register slave.
  modport master (
    output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write,
           csb2nvdla_nposted, prdata, pready, pslverr,
    input  csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
           psel, penable, pwrite, paddr, pwdata, bridge_err
  );

endinterface

`default_nettype wire

// File: rtl/csb2apb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// csb2apb_timeout_cnt : APB wait-state counter with terminal flag. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csb2apb_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      logic w_unused_cnt;
      assign w_unused_cnt = ^r_cnt;
      assign o_term       = 1'b0;
    end else begin : g_timeout
      localparam logic [CW-1:0] c_TERM = CW'(TIMEOUT - 1);
      assign o_term = (r_cnt == c_TERM);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/csb2apb_bridge.sv
// ---------------------------------------------------------------------------
// csb2apb_bridge : CSB responder issuing one APB3 transfer per request. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csb2apb_bridge
  import csb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 256
) (
  input  logic             pclk,
  input  logic             prstn,
  csb2apb_bridge_if.slave  bus
);

  state_e        r_state;
  state_e        w_next;
  logic [DW-1:0] r_paddr;
  logic [DW-1:0] r_wdat;
  logic [DW-1:0] r_rdata;
  logic          r_write;
  logic          r_nposted;
  logic          r_err;

  logic w_ready;
  logic w_psel;
  logic w_penable;
  logic w_rsp_valid;
  logic w_wr_cpl;
  logic w_err;
  logic w_accept;
  logic w_wait;
  logic w_term;
  logic w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && bus.csb2nvdla_valid;
  assign w_wait    = (r_state == ST_ACCESS) && !bus.pready;
  assign w_timeout = w_wait && w_term;

  csb2apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (pclk),
    .rst_n  (prstn),
    .i_clr  (w_accept),
    .i_en   (w_wait),
    .o_term (w_term)
  );

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_rsp_valid = 1'b0;
    w_wr_cpl    = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.csb2nvdla_valid) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        w_psel = 1'b1;
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (bus.pready || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid = !r_write;
        w_wr_cpl    = r_write && r_nposted;
        w_err       = r_err;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read data is only replaced by a read completion, so it holds across writes.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      r_paddr   <= '0;
      r_wdat    <= '0;
      r_rdata   <= '0;
      r_write   <= 1'b0;
      r_nposted <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_paddr   <= make_paddr(BASE_ADDR[31:18], bus.csb2nvdla_addr);
        r_wdat    <= bus.csb2nvdla_wdat;
        r_write   <= bus.csb2nvdla_write;
        r_nposted <= bus.csb2nvdla_nposted;
        r_err     <= 1'b0;
      end
      if (r_state == ST_ACCESS) begin
        if (bus.pready) begin
          r_err <= bus.pslverr;
          if (!r_write) r_rdata <= bus.pslverr ? '0 : bus.prdata;
        end else if (w_timeout) begin
          r_err <= 1'b1;
          if (!r_write) r_rdata <= '0;
        end
      end
    end
  end

  assign bus.csb2nvdla_ready       = w_ready;
  assign bus.nvdla2csb_valid       = w_rsp_valid;
  assign bus.nvdla2csb_data        = r_rdata;
  assign bus.nvdla2csb_wr_complete = w_wr_cpl;
  assign bus.psel                  = w_psel;
  assign bus.penable               = w_penable;
  assign bus.pwrite                = r_write;
  assign bus.paddr                 = r_paddr;
  assign bus.pwdata                = r_wdat;
  assign bus.bridge_err            = w_err;

endmodule

`default_nettype wire

// File: tb/tb_csb2apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_csb2apb_bridge : directed vector bench for csb2apb_bridge. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_csb2apb_bridge;

  logic pclk;
  logic prstn;

  csb2apb_bridge_if bus ();

  csb2apb_bridge #(
    .BASE_ADDR (32'h8004_1234),
    .TIMEOUT   (4)
  ) dut (
    .pclk  (pclk),
    .prstn (prstn),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic        np;
    logic        hold;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] prd;
    logic        slverr;
    int          waits;
    logic [31:0] exp_paddr;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[11];
  int          n_chk;
  int          n_bad;
  logic [31:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int   cyc, acc, n_valid, n_wrc, n_err;
    logic done, stable, overlap;
    logic [31:0] got_data;
    cyc = 0; acc = 0; n_valid = 0; n_wrc = 0; n_err = 0;
    done = 1'b0; stable = 1'b1; overlap = 1'b0; got_data = 32'h0;

    chk($sformatf("v%0d ready_idle", idx), 32'(bus.csb2nvdla_ready), 32'd1);
    bus.csb2nvdla_valid   = 1'b1;
    bus.csb2nvdla_addr    = v.addr;
    bus.csb2nvdla_wdat    = v.wdat;
    bus.csb2nvdla_write   = v.wr;
    bus.csb2nvdla_nposted = v.np;
    @(posedge pclk); #1; cyc = 1;
    if (v.hold) begin
      bus.csb2nvdla_addr = ~v.addr;
      bus.csb2nvdla_wdat = ~v.wdat;
    end else begin
      bus.csb2nvdla_valid = 1'b0;
    end

    chk($sformatf("v%0d setup_psel_pen", idx), {30'd0, bus.psel, bus.penable}, 32'd2);
    chk($sformatf("v%0d setup_ready", idx), 32'(bus.csb2nvdla_ready), 32'd0);
    chk($sformatf("v%0d paddr", idx), bus.paddr, v.exp_paddr);
    chk($sformatf("v%0d pwrite", idx), 32'(bus.pwrite), 32'(v.wr));
    if (v.wr) chk($sformatf("v%0d pwdata", idx), bus.pwdata, v.wdat);

    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge pclk); #1; cyc++;
      if (bus.nvdla2csb_valid) begin n_valid++; got_data = bus.nvdla2csb_data; end
      if (bus.nvdla2csb_wr_complete) n_wrc++;
      if (bus.bridge_err) n_err++;
      if (bus.psel && (bus.nvdla2csb_valid || bus.nvdla2csb_wr_complete || bus.bridge_err))
        overlap = 1'b1;
      if (bus.psel && bus.penable) begin
        acc++;
        if (bus.paddr !== v.exp_paddr || bus.pwrite !== v.wr || (v.wr && bus.pwdata !== v.wdat))
          stable = 1'b0;
        if (acc - 1 == v.waits) begin
          bus.pready = 1'b1; bus.prdata = v.prd; bus.pslverr = v.slverr;
        end else begin
          bus.pready = 1'b0; bus.prdata = 32'h0BAD_0BAD; bus.pslverr = 1'b0;
        end
      end else begin
        bus.pready = 1'b0; bus.pslverr = 1'b0;
        if (!bus.csb2nvdla_ready && !bus.psel) bus.csb2nvdla_valid = 1'b0;
        if (bus.csb2nvdla_ready) done = 1'b1;
      end
    end

    chk($sformatf("v%0d completed", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(3 + v.exp_acc));
    chk($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.exp_acc));
    chk($sformatf("v%0d apb_stable", idx), 32'(stable), 32'd1);
    chk($sformatf("v%0d no_overlap", idx), 32'(overlap), 32'd0);
    chk($sformatf("v%0d rsp_valid_cnt", idx), 32'(n_valid), v.wr ? 32'd0 : 32'd1);
    chk($sformatf("v%0d wr_cpl_cnt", idx), 32'(n_wrc), (v.wr && v.np) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d err_cnt", idx), 32'(n_err), 32'(v.exp_err));
    if (!v.wr) begin
      chk($sformatf("v%0d rdata", idx), got_data, v.exp_data);
      last_data = v.exp_data;
    end
    chk($sformatf("v%0d data_hold", idx), bus.nvdla2csb_data, last_data);
  endtask

  initial begin
    n_chk = 0; n_bad = 0; last_data = 32'h0;
    //        wr    np    hold  addr      wdat          prd           slverr waits paddr          acc err   data
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0012, 32'h0,        32'hDEADBEEF, 1'b0, 0,  32'h8004_0048, 1, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 32'hA5A5_0001, 32'h0,       1'b0, 3,  32'h8004_0400, 4, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0200, 32'h1234_5678, 32'h0,       1'b0, 0,  32'h8004_0800, 1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0201, 32'h0,        32'hCAFEF00D, 1'b0, 1,  32'h8004_0804, 2, 1'b0, 32'hCAFEF00D};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 32'h0,        32'h1111_1111, 1'b1, 0, 32'h8004_0010, 1, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0005, 32'h0,        32'h2222_2222, 1'b0, 99, 32'h8004_0014, 4, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0007, 32'h0,        32'h5A5A_5A5A, 1'b0, 0, 32'h8004_001C, 1, 1'b0, 32'h5A5A_5A5A};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0,        32'h0BAD_F00D, 1'b0, 2, 32'h8007_FFFC, 3, 1'b0, 32'h0BAD_F00D};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 32'h0F0F_0F0F, 32'h0,       1'b1, 1,  32'h8004_48D0, 2, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0040, 32'h0,        32'h1357_9BDF, 1'b0, 3, 32'h8004_0100, 4, 1'b0, 32'h1357_9BDF};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0041, 32'hFFFF_FFFF, 32'h0,       1'b1, 0,  32'h8004_0104, 1, 1'b1, 32'h0};

    prstn = 1'b0;
    bus.csb2nvdla_valid = 1'b0; bus.csb2nvdla_addr = 16'h0; bus.csb2nvdla_wdat = 32'h0;
    bus.csb2nvdla_write = 1'b0; bus.csb2nvdla_nposted = 1'b0;
    bus.prdata = 32'h0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    #12;
    chk("rst ready", 32'(bus.csb2nvdla_ready), 32'd1);
    chk("rst apb ctl", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
    chk("rst paddr", bus.paddr, 32'h0);
    chk("rst pwdata", bus.pwdata, 32'h0);
    chk("rst rsp", {29'd0, bus.nvdla2csb_valid, bus.nvdla2csb_wr_complete, bus.bridge_err}, 32'd0);
    chk("rst data", bus.nvdla2csb_data, 32'h0);
    @(posedge pclk); #1; prstn = 1'b1;
    @(posedge pclk); #1;

    for (int k = 0; k < 11; k++) run(vecs[k], k);

    // Reset while the slave is stalling in ACCESS.
    bus.csb2nvdla_valid = 1'b1; bus.csb2nvdla_addr = 16'h0033;
    bus.csb2nvdla_write = 1'b0; bus.csb2nvdla_nposted = 1'b0;
    @(posedge pclk); #1; bus.csb2nvdla_valid = 1'b0;
    @(posedge pclk); #1;
    chk("mid access penable", 32'(bus.penable), 32'd1);
    @(posedge pclk); #3;
    prstn = 1'b0;
    #1;
    chk("mid rst ready", 32'(bus.csb2nvdla_ready), 32'd1);
    chk("mid rst apb ctl", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
    chk("mid rst paddr", bus.paddr, 32'h0);
    chk("mid rst data", bus.nvdla2csb_data, 32'h0);
    chk("mid rst rsp", {29'd0, bus.nvdla2csb_valid, bus.nvdla2csb_wr_complete, bus.bridge_err}, 32'd0);
    @(posedge pclk); #1; prstn = 1'b1; last_data = 32'h0;
    begin
      int stray;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge pclk); #1;
        if (bus.psel || bus.nvdla2csb_valid || bus.nvdla2csb_wr_complete || bus.bridge_err) stray++;
      end
      chk("post rst quiet", 32'(stray), 32'd0);
    end
    run(vecs[0], 11);
    run(vecs[1], 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
